led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED animation core driving a WIDTH-bit output pattern from four selectable animation modes, a 16-step speed control and a direction control. It generalises the fixed-width speed/direction animator behind the top-level wrapper, and adds bounce and rotate modes, pause, a configurable width and seed, and a per-frame strobe. It sits between the wrapper's input pins (speed, direction, mode, pause) and the output pins.

## Interface
- WIDTH, 8: pattern width in bits, legal range 2..32.
- BASE_DIV, 4: clock cycles per speed unit, legal range 1..64.
- SEED, {WIDTH/4 copies of 4'b0001}: initial ROTATE pattern, 0x11 for WIDTH=8.
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- ena  in  1  global enable; low behaves as pause.
- speed  in  4  0 is slowest, 15 is fastest.
- dir  in  1  0 = up/left, 1 = down/right.
- mode  in  2  0 SCAN, 1 FILL, 2 BOUNCE, 3 ROTATE.
- pause  in  1  freezes the divider and animation state.
- pattern_out  out  WIDTH  current frame.
- frame_tick  out  1  one-cycle pulse marking a new frame.

## Operation
- Divider: div_cnt is sized to hold 16*BASE_DIV. limit = (16-speed)*BASE_DIV-1.
  - In a run cycle (ena=1, pause=0), advance is asserted when div_cnt >= limit, and div_cnt then returns to 0. Otherwise div_cnt increments.
  - The >= compare means that lowering limit mid-count fires advance on the next run cycle.
- State registers: pos (index width), len (0..WIDTH), bdir, pat[WIDTH-1:0], mode_q[1:0].
- Reset values: div_cnt=0, pos=0, len=0, bdir=0, pat=SEED, mode_q=0, frame_tick=0. pattern_out therefore resets to 0x01.
- mode_q samples mode every cycle.
  - When mode != mode_q, the state reinitialises to its reset values, div_cnt goes to 0 and frame_tick stays 0. mode_q takes the new value on the same edge.
  - Reinit takes priority over advance.
- On advance, per mode_q:
  - SCAN: pos steps ±1 with wrap. dir=0 steps up (WIDTH-1 wraps to 0); dir=1 steps down (0 wraps to WIDTH-1). Output is 1<<pos.
  - FILL: dir=0 gives len+1, wrapping WIDTH→0. dir=1 gives len-1, wrapping 0→WIDTH. Output is (1<<len)-1, with len=WIDTH giving all ones.
  - BOUNCE: dir is ignored. The bdir=0 direction moves up; at pos=WIDTH-1 it sets bdir=1 and moves to WIDTH-2. The bdir=1 direction moves down; at pos=0 it clears bdir and moves to 1. Output is 1<<pos. Endpoints are shown once per pass.
  - ROTATE: dir=0 rotates pat left by 1; dir=1 rotates right. Output is pat.
- pattern_out is a combinational decode of the registered state and mode_q; there is no extra register stage.
- pause, or ena=0: div_cnt and all animation state hold, and pattern_out holds.
  - Resuming continues from the held div_cnt without restarting the period.
  - Mode change while paused still reinitialises.
- dir change takes effect on the next advance; it causes no reinit.

## Timing
- Advance cycle N: state updates at edge N. frame_tick is high during cycle N+1, together with the new pattern_out.
- Frame period while running = (16-speed)*BASE_DIV cycles. speed=3 with BASE_DIV=4 gives 52 cycles; speed=15 gives 4.
- First advance after reset release, or after reinit, occurs on the limit+1-th run cycle.
- Reset assertion clears all state asynchronously, mid-frame included. Outputs take reset values immediately.
- Mode change: new mode's initial pattern appears the cycle after mode is sampled different (1-cycle latency).

## Configuration
- LPE_BOUNCE_EN defined: BOUNCE mode implemented as above.
- LPE_BOUNCE_EN undefined: the bdir register is removed, and mode 2 behaves exactly as SCAN, including dir handling and wrap.

## Test plan
- Reset release with mode=0, dir=0, speed=3 -> pattern_out is 0x01. After 52 cycles comes 0x02 with frame_tick high for 1 cycle; after 3 frames the pattern is 0x08; after 8 frames it wraps back to 0x01.
- SCAN, dir=1 from reset -> first frame 0x80, second frame 0x40. Switching to mode=1 -> 0x00 one cycle later, then frames 0x01, 0x03, …, 0xFF, 0x00.
- mode=2 (LPE_BOUNCE_EN defined), speed=15 -> sequence 0x01, 0x02, …, 0x80, 0x40, …, 0x01, 0x02, with frames 4 cycles apart. With LPE_BOUNCE_EN undefined, 0x80 is followed by 0x01.
- mode=3, dir=0 -> 0x11, 0x22, 0x44, 0x88, 0x11. Flipping dir to 1 -> next frame 0x44.
- pause=1 asserted 20 cycles into a 52-cycle frame, held 100 cycles, then released -> no frame_tick or pattern change while paused; next frame arrives 32 cycles after release. ena=0 gives identical behaviour.
- rst_n pulsed low mid-frame in ROTATE with pat=0x44 -> pattern_out and state reset immediately. After release, with mode still 3, reinit fires: pattern is 0x11 on the second cycle, and the first frame is after 52 more run cycles.

Source files
------------

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//   LED animation core producing a WIDTH-bit frame from one of four modes
//   (SCAN, FILL, BOUNCE, ROTATE) at a 16-step speed, with direction control,
//   pause/enable and a one-cycle strobe per new frame.
//
// Parameters
//   WIDTH    : pattern width, 2..32
//   BASE_DIV : clock cycles per speed unit, 1..64
//   SEED     : initial ROTATE pattern (default 0x11 for WIDTH=8)
//
// Ports
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   ena         : global enable, low acts as pause
//   speed[3:0]  : 0 slowest .. 15 fastest; frame period (16-speed)*BASE_DIV
//   dir         : 0 = up/left, 1 = down/right
//   mode[1:0]   : 0 SCAN, 1 FILL, 2 BOUNCE, 3 ROTATE
//   pause       : freezes divider and animation state
//   pattern_out : current frame (combinational decode of registered state)
//   frame_tick  : one-cycle pulse alongside each new frame
//
// Build option
//   LPE_BOUNCE_EN : when defined, mode 2 is a ping-pong BOUNCE; otherwise the
//                   bounce direction register is dropped and mode 2 is SCAN.

module led_pattern_engine #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      BASE_DIV = 4,
  parameter logic [WIDTH-1:0] SEED     =
    WIDTH'(64'h1111_1111_1111_1111 & ((64'd1 << (4 * (WIDTH / 4))) - 64'd1))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [3:0]       speed,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [WIDTH-1:0] pattern_out,
  output logic             frame_tick
);

  localparam int unsigned DIV_W = $clog2(16 * BASE_DIV + 1);
  localparam int unsigned POS_W = $clog2(WIDTH);
  localparam int unsigned LEN_W = $clog2(WIDTH + 1);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    MODE_SCAN   = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [POS_W-1:0] pos_q,     pos_d;
  logic [LEN_W-1:0] len_q,     len_d;
  logic [WIDTH-1:0] pat_q,     pat_d;
  mode_e            mode_q,    mode_d;
  logic             frame_tick_q, frame_tick_d;
`ifdef LPE_BOUNCE_EN
  logic             bdir_q,    bdir_d;
`endif

  logic [DIV_W-1:0] limit;
  logic             run;
  logic             advance;
  mode_e            mode_in;

  // Next-state logic: reinit on a mode change beats everything, including
  // pause; otherwise state only moves in a run cycle that reaches the limit.
  always_comb begin
    mode_in = mode_e'(mode);
    limit   = DIV_W'((32'd16 - 32'(speed)) * BASE_DIV - 32'd1);
    run     = ena && !pause;
    // >= so that lowering the limit mid-count fires on the next run cycle
    advance = run && (div_cnt_q >= limit);

    div_cnt_d    = div_cnt_q;
    pos_d        = pos_q;
    len_d        = len_q;
    pat_d        = pat_q;
    mode_d       = mode_in;
    frame_tick_d = 1'b0;
`ifdef LPE_BOUNCE_EN
    bdir_d       = bdir_q;
`endif

    if (mode_in != mode_q) begin
      div_cnt_d = '0;
      pos_d     = '0;
      len_d     = '0;
      pat_d     = SEED;
`ifdef LPE_BOUNCE_EN
      bdir_d    = 1'b0;
`endif
    end else if (advance) begin
      div_cnt_d    = '0;
      frame_tick_d = 1'b1;
      case (mode_q)
        MODE_FILL: begin
          if (dir) len_d = (len_q == '0)      ? LEN_MAX : len_q - LEN_W'(1);
          else     len_d = (len_q == LEN_MAX) ? '0      : len_q + LEN_W'(1);
        end
        MODE_ROTATE: begin
          if (dir) pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
          else     pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        end
`ifdef LPE_BOUNCE_EN
        MODE_BOUNCE: begin
          // Turn-around lands one step inside, so each endpoint shows once.
          if (!bdir_q) begin
            if (pos_q == POS_MAX) begin
              bdir_d = 1'b1;
              pos_d  = POS_MAX - POS_W'(1);
            end else begin
              pos_d  = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              bdir_d = 1'b0;
              pos_d  = POS_W'(1);
            end else begin
              pos_d  = pos_q - POS_W'(1);
            end
          end
        end
`endif
        default: begin
          if (dir) pos_d = (pos_q == '0)      ? POS_MAX : pos_q - POS_W'(1);
          else     pos_d = (pos_q == POS_MAX) ? '0      : pos_q + POS_W'(1);
        end
      endcase
    end else if (run) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      pos_q        <= '0;
      len_q        <= '0;
      pat_q        <= SEED;
      mode_q       <= MODE_SCAN;
      frame_tick_q <= 1'b0;
`ifdef LPE_BOUNCE_EN
      bdir_q       <= 1'b0;
`endif
    end else begin
      div_cnt_q    <= div_cnt_d;
      pos_q        <= pos_d;
      len_q        <= len_d;
      pat_q        <= pat_d;
      mode_q       <= mode_d;
      frame_tick_q <= frame_tick_d;
`ifdef LPE_BOUNCE_EN
      bdir_q       <= bdir_d;
`endif
    end
  end

  logic [WIDTH-1:0] onehot;
  logic [WIDTH-1:0] fill;

  // Output decode straight from registered state; no extra pipeline stage.
  always_comb begin
    onehot = '0;
    fill   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      onehot[i] = (pos_q == POS_W'(i));
      fill[i]   = (LEN_W'(i) < len_q);
    end
    case (mode_q)
      MODE_FILL:   pattern_out = fill;
      MODE_ROTATE: pattern_out = pat_q;
      default:     pattern_out = onehot;
    endcase
  end

  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] speed;
  logic       dir;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] pattern_out;
  logic       frame_tick;

  int unsigned tests = 0;
  int unsigned fails = 0;

  led_pattern_engine #(
    .WIDTH    (8),
    .BASE_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .speed       (speed),
    .dir         (dir),
    .mode        (mode),
    .pause       (pause),
    .pattern_out (pattern_out),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count negedges until frame_tick is seen (bounded), then check the
  // elapsed cycle count and the new pattern.
  task automatic next_frame(input string tag, input int exp_n, input logic [7:0] exp_pat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 300);
    check_eq({tag, " period"}, n, exp_n);
    check_eq({tag, " pattern"}, pattern_out, exp_pat);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  logic [7:0] bseq [$];

  initial begin
    rst_n = 1'b0; ena = 1'b1; speed = 4'd3; dir = 1'b0; mode = 2'd0; pause = 1'b0;
    step(2);
    check_eq("reset pattern", pattern_out, 8'h01);
    check_eq("reset tick", frame_tick, 1'b0);
    rst_n = 1'b1;

    // SCAN up, speed 3 -> 52-cycle frames
    next_frame("scan f1", 52, 8'h02);
    step(1);
    check_eq("tick one cycle", frame_tick, 1'b0);
    next_frame("scan f2", 51, 8'h04);
    next_frame("scan f3", 52, 8'h08);
    next_frame("scan f4", 52, 8'h10);
    next_frame("scan f5", 52, 8'h20);
    next_frame("scan f6", 52, 8'h40);
    next_frame("scan f7", 52, 8'h80);
    next_frame("scan wrap", 52, 8'h01);

    // Lowering the limit mid-count fires on the next run cycle
    step(20);
    speed = 4'd15;
    next_frame("limit drop", 1, 8'h02);
    next_frame("speed15", 4, 8'h04);
    speed = 4'd3;

    // SCAN down from reset
    dir = 1'b1;
    do_reset();
    next_frame("scan down f1", 52, 8'h80);
    next_frame("scan down f2", 52, 8'h40);

    // FILL: mode change reinit, then up through all-ones and wrap
    mode = 2'd1; dir = 1'b0;
    step(1);
    check_eq("fill reinit", pattern_out, 8'h00);
    check_eq("fill reinit tick", frame_tick, 1'b0);
    next_frame("fill 1", 52, 8'h01);
    next_frame("fill 2", 52, 8'h03);
    next_frame("fill 3", 52, 8'h07);
    next_frame("fill 4", 52, 8'h0F);
    next_frame("fill 5", 52, 8'h1F);
    next_frame("fill 6", 52, 8'h3F);
    next_frame("fill 7", 52, 8'h7F);
    next_frame("fill 8", 52, 8'hFF);
    next_frame("fill wrap", 52, 8'h00);
    dir = 1'b1;
    next_frame("fill down wrap", 52, 8'hFF);
    next_frame("fill down", 52, 8'h7F);

    // BOUNCE (or SCAN when the bounce build option is off), speed 15
`ifdef LPE_BOUNCE_EN
    bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`else
    bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
`endif
    mode = 2'd2; dir = 1'b0; speed = 4'd15;
    step(1);
    check_eq("bounce reinit", pattern_out, 8'h01);
    foreach (bseq[i]) next_frame($sformatf("bounce %0d", i), 4, bseq[i]);

    // ROTATE
    mode = 2'd3; dir = 1'b0; speed = 4'd3;
    step(1);
    check_eq("rotate reinit", pattern_out, 8'h11);
    next_frame("rot 1", 52, 8'h22);
    next_frame("rot 2", 52, 8'h44);
    next_frame("rot 3", 52, 8'h88);
    dir = 1'b1;
    next_frame("rot right", 52, 8'h44);
    dir = 1'b0;
    next_frame("rot left 1", 52, 8'h88);
    next_frame("rot left 2", 52, 8'h11);

    // pause 20 cycles into a frame, hold 100, resume with 32 left
    step(20);
    pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check_eq("paused tick", frame_tick, 1'b0);
      check_eq("paused pattern", pattern_out, 8'h11);
    end
    pause = 1'b0;
    next_frame("pause resume", 32, 8'h22);

    // ena=0 behaves the same
    step(20);
    ena = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check_eq("ena0 tick", frame_tick, 1'b0);
      check_eq("ena0 pattern", pattern_out, 8'h22);
    end
    ena = 1'b1;
    next_frame("ena resume", 32, 8'h44);

    // mode change while paused still reinitialises
    pause = 1'b1; mode = 2'd0;
    step(1);
    check_eq("paused reinit", pattern_out, 8'h01);
    step(5);
    check_eq("paused reinit hold", pattern_out, 8'h01);
    pause = 1'b0;
    next_frame("post pause reinit", 52, 8'h02);

    // async reset mid-frame in ROTATE with pat=0x44
    mode = 2'd3;
    step(1);
    check_eq("rot2 reinit", pattern_out, 8'h11);
    next_frame("rot2 f1", 52, 8'h22);
    next_frame("rot2 f2", 52, 8'h44);
    step(10);
    rst_n = 1'b0;
    #1;
    check_eq("async reset pattern", pattern_out, 8'h01);
    check_eq("async reset tick", frame_tick, 1'b0);
    step(2);
    rst_n = 1'b1;
    #1;
    check_eq("post reset pattern", pattern_out, 8'h01);
    step(1);
    check_eq("post reset reinit", pattern_out, 8'h11);
    next_frame("post reset f1", 52, 8'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
